reg_write_arbiter: RTL and testbench

Shares the register file's single write port (`w_enable`/`w_addr`/`w_data`) between several requesters: the CPU execute stage, the RAM load unit, and the interrupt context path. Each requester gets a one-entry holding slot behind a valid/ready handshake. An arbiter drains one slot per cycle into a registered write port. Writes to read-only addresses (above 6'h1f) are consumed but never reach the register file, and each one is flagged.

---
 rtl/reg_write_arbiter_pkg.sv | 28 ++
 rtl/reg_write_arbiter_rr_arbiter.sv | 54 +++++
 rtl/reg_write_arbiter.sv | 155 +++++++++++++++
 tb/tb_reg_write_arbiter.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/reg_write_arbiter_pkg.sv
// reg_write_arbiter_pkg: shared constants for the register-file write arbiter.
// Holds requester indices, the default writable-address limit and the
// round-robin pointer helper used when REG_ARB_ROUND_ROBIN_EN is defined.
package reg_write_arbiter_pkg;

   // Width of a requester index (pointer, grant index, reject_id).
   localparam int REQ_IDX_W = 2;

   // Requester identities, in fixed-priority order (lowest index wins).
   typedef enum logic [REQ_IDX_W-1:0] {
      REQ_EXEC = 2'd0,
      REQ_LOAD = 2'd1,
      REQ_INT  = 2'd2
   } req_id_e;

   // Highest writable register address; anything above is read-only.
   localparam logic [5:0] RW_LAST_DEFAULT = 6'h1f;

   // Pointer value after a grant to idx: one past it, wrapping at num_req.
   function automatic logic [REQ_IDX_W-1:0] next_ptr(input logic [REQ_IDX_W-1:0] idx,
                                                     input int num_req);
      if (int'(idx) >= num_req - 1) begin
         return '0;
      end
      return idx + 1'b1;
   endfunction

endpackage

// File: rtl/reg_write_arbiter_rr_arbiter.sv
// rr_arbiter: combinational one-hot grant over a request vector.
// REG_ARB_ROUND_ROBIN_EN defined: search starts at i_ptr and wraps upward.
// Otherwise: fixed priority, lowest index wins, i_ptr is ignored.
module rr_arbiter
   import reg_write_arbiter_pkg::*;
#(
   parameter int NUM_REQ = 3
) (
   input  logic [NUM_REQ-1:0]   i_req,
   input  logic [REQ_IDX_W-1:0] i_ptr,
   output logic [NUM_REQ-1:0]   o_grant
);

`ifdef REG_ARB_ROUND_ROBIN_EN
   // Walk priority ranks starting at the pointer; first requesting slot wins.
   always_comb begin
      logic w_found;
      int   w_pos;
      o_grant = '0;
      w_found = 1'b0;
      w_pos   = 0;
      for (int off = 0; off < NUM_REQ; off++) begin
         w_pos = int'(i_ptr) + off;
         if (w_pos >= NUM_REQ) begin
            w_pos = w_pos - NUM_REQ;
         end
         for (int i = 0; i < NUM_REQ; i++) begin
            if (!w_found && i_req[i] && (w_pos == i)) begin
               o_grant[i] = 1'b1;
               w_found    = 1'b1;
            end
         end
      end
   end
`else
   // The pointer has no meaning under fixed priority.
   logic w_unused_ptr;
   assign w_unused_ptr = ^i_ptr;

   // Lowest requesting index wins.
   always_comb begin
      logic w_found;
      o_grant = '0;
      w_found = 1'b0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (!w_found && i_req[i]) begin
            o_grant[i] = 1'b1;
            w_found    = 1'b1;
         end
      end
   end
`endif

endmodule

// File: rtl/reg_write_arbiter.sv
// reg_write_arbiter: shares the register file's single write port between
// the execute stage, the load unit and the interrupt context path.
// Each requester owns a one-entry slot; one slot drains per cycle into a
// registered write port. Writes above RW_LAST are dropped and flagged.
// Optional macro REG_ARB_ROUND_ROBIN_EN selects round-robin arbitration
// (default build: fixed priority, execute > load > interrupt).
module reg_write_arbiter
   import reg_write_arbiter_pkg::*;
#(
   parameter int                NUM_REQ = 3,
   parameter int                ADDR_W  = 6,
   parameter int                DATA_W  = 8,
   parameter logic [ADDR_W-1:0] RW_LAST = ADDR_W'(RW_LAST_DEFAULT)
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [NUM_REQ-1:0]        req_valid,
   output logic [NUM_REQ-1:0]        req_ready,
   input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
   input  logic [NUM_REQ*DATA_W-1:0] req_data,
   output logic                      w_enable,
   output logic [ADDR_W-1:0]         w_addr,
   output logic [DATA_W-1:0]         w_data,
   output logic                      reject,
   output logic [REQ_IDX_W-1:0]      reject_id,
   output logic                      busy
);

   // Holding slots
   logic [NUM_REQ-1:0] r_full;
   logic [ADDR_W-1:0]  r_slot_addr [NUM_REQ];
   logic [DATA_W-1:0]  r_slot_data [NUM_REQ];

   // Unpacked views of the request buses
   logic [ADDR_W-1:0]  w_in_addr [NUM_REQ];
   logic [DATA_W-1:0]  w_in_data [NUM_REQ];

   // Arbitration
   logic [REQ_IDX_W-1:0] w_ptr;
   logic [NUM_REQ-1:0]   w_grant;
   logic                 w_grant_any;
   logic [REQ_IDX_W-1:0] w_grant_idx;
   logic [ADDR_W-1:0]    w_sel_addr;
   logic [DATA_W-1:0]    w_sel_data;
   logic                 w_sel_ro;

   // Output registers
   logic                 r_w_enable;
   logic [ADDR_W-1:0]    r_w_addr;
   logic [DATA_W-1:0]    r_w_data;
   logic                 r_reject;
   logic [REQ_IDX_W-1:0] r_reject_id;

   for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
      assign w_in_addr[gi] = req_addr[gi*ADDR_W +: ADDR_W];
      assign w_in_data[gi] = req_data[gi*DATA_W +: DATA_W];
   end

   // A slot being drained this cycle can take a new entry on the same edge.
   // Ready depends only on state, never on req_valid.
   assign req_ready = ~r_full | w_grant;
   assign busy      = |r_full;

`ifdef REG_ARB_ROUND_ROBIN_EN
   logic [REQ_IDX_W-1:0] r_ptr;
   assign w_ptr = r_ptr;

   // Pointer moves one past the winner after every grant, holds otherwise.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_ptr <= '0;
      end else if (w_grant_any) begin
         r_ptr <= next_ptr(w_grant_idx, NUM_REQ);
      end
   end
`else
   assign w_ptr = '0;
`endif

   rr_arbiter #(
      .NUM_REQ (NUM_REQ)
   ) u_arb (
      .i_req   (r_full),
      .i_ptr   (w_ptr),
      .o_grant (w_grant)
   );

   // Encode the one-hot grant and mux out the winning slot's contents.
   always_comb begin
      w_grant_any = |w_grant;
      w_grant_idx = '0;
      w_sel_addr  = '0;
      w_sel_data  = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (w_grant[i]) begin
            w_grant_idx = REQ_IDX_W'(i);
            w_sel_addr  = r_slot_addr[i];
            w_sel_data  = r_slot_data[i];
         end
      end
      w_sel_ro = (w_sel_addr > RW_LAST);
   end

   // Slots capture on handshake, otherwise empty when their entry wins.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_full <= '0;
         for (int i = 0; i < NUM_REQ; i++) begin
            r_slot_addr[i] <= '0;
            r_slot_data[i] <= '0;
         end
      end else begin
         for (int i = 0; i < NUM_REQ; i++) begin
            if (req_valid[i] && req_ready[i]) begin
               r_full[i]      <= 1'b1;
               r_slot_addr[i] <= w_in_addr[i];
               r_slot_data[i] <= w_in_data[i];
            end else if (w_grant[i]) begin
               r_full[i] <= 1'b0;
            end
         end
      end
   end

   // Register the granted entry as a write or, for read-only targets, a reject.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_w_enable  <= 1'b0;
         r_w_addr    <= '0;
         r_w_data    <= '0;
         r_reject    <= 1'b0;
         r_reject_id <= '0;
      end else begin
         r_w_enable <= 1'b0;
         r_reject   <= 1'b0;
         if (w_grant_any) begin
            if (w_sel_ro) begin
               r_reject    <= 1'b1;
               r_reject_id <= w_grant_idx;
            end else begin
               r_w_enable <= 1'b1;
               r_w_addr   <= w_sel_addr;
               r_w_data   <= w_sel_data;
            end
         end
      end
   end

   assign w_enable  = r_w_enable;
   assign w_addr    = r_w_addr;
   assign w_data    = r_w_data;
   assign reject    = r_reject;
   assign reject_id = r_reject_id;

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Testbench for reg_write_arbiter: directed stimulus with a scoreboard queue
// drained by an independent output monitor. Expectations follow whichever
// arbitration mode REG_ARB_ROUND_ROBIN_EN selects.
module tb_reg_write_arbiter;

   localparam int NUM_REQ = 3;
   localparam int ADDR_W  = 6;
   localparam int DATA_W  = 8;

   logic                      clk = 1'b0;
   logic                      rst = 1'b0;
   logic [NUM_REQ-1:0]        req_valid = '0;
   logic [NUM_REQ-1:0]        req_ready;
   logic [NUM_REQ*ADDR_W-1:0] req_addr = '0;
   logic [NUM_REQ*DATA_W-1:0] req_data = '0;
   logic                      w_enable;
   logic [ADDR_W-1:0]         w_addr;
   logic [DATA_W-1:0]         w_data;
   logic                      reject;
   logic [1:0]                reject_id;
   logic                      busy;

   typedef struct packed {
      logic              is_rej;
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] data;
      logic [1:0]        id;
   } exp_t;

   exp_t exp_q[$];
   exp_t mon_e;
   int   n_checks = 0;
   int   n_fail   = 0;

   reg_write_arbiter #(
      .NUM_REQ (NUM_REQ),
      .ADDR_W  (ADDR_W),
      .DATA_W  (DATA_W)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_addr  (req_addr),
      .req_data  (req_data),
      .w_enable  (w_enable),
      .w_addr    (w_addr),
      .w_data    (w_data),
      .reject    (reject),
      .reject_id (reject_id),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cyc();
   endtask

   task automatic set_req(input int id, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
      req_addr[id*ADDR_W +: ADDR_W] = a;
      req_data[id*DATA_W +: DATA_W] = d;
   endtask

   task automatic push_wr(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
      exp_q.push_back('{is_rej: 1'b0, addr: a, data: d, id: 2'd0});
   endtask

   task automatic push_rej(input logic [1:0] id);
      exp_q.push_back('{is_rej: 1'b1, addr: '0, data: '0, id: id});
   endtask

   task automatic do_reset();
      rst = 1'b0;
      cyc();
      rst = 1'b1;
      cyc();
   endtask

   // One request from one requester, then let it drain.
   task automatic single(input int id, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                         input logic ro);
      if (ro) push_rej(2'(id));
      else    push_wr(a, d);
      set_req(id, a, d);
      req_valid = '0;
      req_valid[id] = 1'b1;
      cyc();
      req_valid = '0;
      idle(3);
   endtask

   // Monitor: every write or reject the DUT presents is matched to the queue head.
   always @(negedge clk) begin
      if (rst && (w_enable || reject)) begin
         if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_output: w_enable=%0b reject=%0b addr=0x%0h data=0x%0h, required no output",
                     w_enable, reject, w_addr, w_data);
         end else begin
            mon_e = exp_q.pop_front();
            if (mon_e.is_rej) begin
               $display("reject id=%0d (expected id=%0d)", reject_id, mon_e.id);
               chk("mon_reject_flag", reject, 1);
               chk("mon_reject_wen", w_enable, 0);
               chk("mon_reject_id", reject_id, mon_e.id);
            end else begin
               $display("write addr=0x%02h data=0x%02h (expected 0x%02h/0x%02h)",
                        w_addr, w_data, mon_e.addr, mon_e.data);
               chk("mon_write_en", w_enable, 1);
               chk("mon_write_noreject", reject, 0);
               chk("mon_write_addr", w_addr, mon_e.addr);
               chk("mon_write_data", w_data, mon_e.data);
            end
         end
      end
   end

   logic       s0, s2;
   int         k0, k2, exp_k0;
   logic [4:0] rdy0_tbl, rdy2_tbl;

   initial begin
      // ---------------- reset state ----------------
      rst = 1'b0;
      req_valid = '0;
      cyc();
      cyc();
      chk("reset_wen", w_enable, 0);
      chk("reset_waddr", w_addr, 0);
      chk("reset_wdata", w_data, 0);
      chk("reset_reject", reject, 0);
      chk("reset_reject_id", reject_id, 0);
      chk("reset_busy", busy, 0);
      chk("reset_ready", req_ready, 3'b111);
      rst = 1'b1;
      cyc();

      // ---------------- single write, latency ----------------
      set_req(0, 6'h05, 8'hA5);
      req_valid = 3'b001;
      push_wr(6'h05, 8'hA5);
      cyc();
      req_valid = '0;
      chk("t1_busy_after_accept", busy, 1);
      chk("t1_wen_before_grant", w_enable, 0);
      cyc();
      chk("t1_wen", w_enable, 1);
      chk("t1_waddr", w_addr, 6'h05);
      chk("t1_wdata", w_data, 8'hA5);
      chk("t1_busy_cleared", busy, 0);
      cyc();
      chk("t1_wen_one_cycle", w_enable, 0);
      idle(2);

      // ---------------- three simultaneous requests ----------------
      do_reset();
      set_req(0, 6'h01, 8'h11);
      set_req(1, 6'h02, 8'h22);
      set_req(2, 6'h03, 8'h33);
      push_wr(6'h01, 8'h11);
      push_wr(6'h02, 8'h22);
      push_wr(6'h03, 8'h33);
      req_valid = 3'b111;
      cyc();
      req_valid = '0;
      chk("t2_ready_after_fill", req_ready, 3'b001);
      cyc();
      chk("t2_ready2_second", req_ready[2], 0);
      chk("t2_first_addr", w_addr, 6'h01);
      cyc();
      chk("t2_ready2_freed", req_ready[2], 1);
      idle(3);

      // ---------------- read-only target rejected ----------------
      set_req(1, 6'h21, 8'h5A);
      push_rej(2'd1);
      chk("t3_ready1_idle", req_ready[1], 1);
      req_valid = 3'b010;
      cyc();
      req_valid = '0;
      chk("t3_reject_not_yet", reject, 0);
      cyc();
      chk("t3_reject", reject, 1);
      chk("t3_reject_id", reject_id, 1);
      chk("t3_no_write", w_enable, 0);
      set_req(1, 6'h04, 8'h44);
      push_wr(6'h04, 8'h44);
      chk("t3_ready1_after_reject", req_ready[1], 1);
      req_valid = 3'b010;
      cyc();
      req_valid = '0;
      chk("t3_reject_one_cycle", reject, 0);
      cyc();
      chk("t3_next_write", w_enable, 1);
      chk("t3_next_addr", w_addr, 6'h04);
      idle(2);

      // ---------------- writable/read-only boundary ----------------
      single(2, 6'h1f, 8'h77, 1'b0);
      single(2, 6'h20, 8'h99, 1'b1);
      single(0, 6'h3f, 8'h01, 1'b1);
      single(1, 6'h00, 8'hEE, 1'b0);

      // ---------------- requesters 0 and 2 held valid ----------------
      do_reset();
`ifdef REG_ARB_ROUND_ROBIN_EN
      push_wr(6'h08, 8'h00);
      push_wr(6'h0A, 8'hC0);
      push_wr(6'h08, 8'h01);
      push_wr(6'h0A, 8'hC1);
      push_wr(6'h08, 8'h02);
      push_wr(6'h0A, 8'hC2);
      rdy0_tbl = 5'b10101;
      rdy2_tbl = 5'b01010;
      exp_k0   = 3;
`else
      push_wr(6'h08, 8'h00);
      push_wr(6'h08, 8'h01);
      push_wr(6'h08, 8'h02);
      push_wr(6'h08, 8'h03);
      push_wr(6'h08, 8'h04);
      push_wr(6'h0A, 8'hC0);
      rdy0_tbl = 5'b11111;
      rdy2_tbl = 5'b00000;
      exp_k0   = 5;
`endif
      k0 = 0;
      k2 = 0;
      set_req(0, 6'h08, 8'h00);
      set_req(2, 6'h0A, 8'hC0);
      req_valid = 3'b101;
      for (int c = 0; c < 5; c++) begin
         s0 = req_ready[0];
         s2 = req_ready[2];
         cyc();
         if (s0) k0++;
         if (s2) k2++;
         set_req(0, 6'h08, 8'(k0));
         set_req(2, 6'h0A, 8'hC0 + 8'(k2));
         chk("t4_ready0", req_ready[0], rdy0_tbl[c]);
         chk("t4_ready2", req_ready[2], rdy2_tbl[c]);
      end
      req_valid = '0;
      chk("t4_accepts_req0", k0, exp_k0);
      idle(4);

      // ---------------- reset while slots are full ----------------
      set_req(0, 6'h10, 8'hD0);
      set_req(1, 6'h11, 8'hD1);
      set_req(2, 6'h12, 8'hD2);
      req_valid = 3'b111;
      cyc();
      req_valid = '0;
      chk("t5_busy_full", busy, 1);
      cyc();
      chk("t5_write_visible", w_enable, 1);
      #1;
      rst = 1'b0;
      #1;
      chk("t5_wen_cleared", w_enable, 0);
      chk("t5_waddr_cleared", w_addr, 0);
      chk("t5_busy_cleared", busy, 0);
      chk("t5_ready_all", req_ready, 3'b111);
      #4;
      rst = 1'b1;
      idle(4);
      chk("t5_busy_after", busy, 0);
      chk("t5_no_stale_write", w_enable, 0);

      // ---------------- single-requester streaming ----------------
      for (int c = 0; c < 8; c++) begin
         set_req(0, 6'h10 + 6'(c), 8'h80 + 8'(c));
         push_wr(6'h10 + 6'(c), 8'h80 + 8'(c));
         req_valid = 3'b001;
         chk("t6_ready0", req_ready[0], 1);
         cyc();
         chk("t6_wen_stream", w_enable, (c >= 1) ? 1 : 0);
      end
      req_valid = '0;
      cyc();
      chk("t6_last_wen", w_enable, 1);
      chk("t6_last_addr", w_addr, 6'h17);
      cyc();
      chk("t6_wen_done", w_enable, 0);
      chk("t6_busy_done", busy, 0);
      idle(3);

      chk("scoreboard_drained", exp_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
